neuron_mac_c9: RTL and testbench

- Output-neuron engine for column 9 of the 300-input output layer.
- Sequences the 9-bit column address into the column-9 weight ROM, which is combinational and returns a 21-bit signed weight. Each weight is multiplied by the matching hidden-layer activation and accumulated over all N_IN terms.
- The result is rescaled and saturated into a single output score.
- Sits directly downstream of the column-9 weight ROM and feeds the argmax/classifier stage.

---
 rtl/neuron_mac_c9_if.sv | 26 ++
 rtl/neuron_mac_c9.sv | 139 +++++++++++++
 tb/tb_neuron_mac_c9.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/neuron_mac_c9_if.sv
// rtl/neuron_mac_c9_if.sv - handshake and ROM/activation bus for the column-9 neuron engine
`timescale 1ns/1ps
interface neuron_mac_c9_if #(
  parameter int ADR_W = 9,
  parameter int W_W   = 21,
  parameter int ACT_W = 16,
  parameter int OUT_W = 16
);
  logic             start;
  logic [ADR_W-1:0] adrs_clm;
  logic [W_W-1:0]   w_in;
  logic [ACT_W-1:0] act_in;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] score;

  modport master (
    output start, w_in, act_in,
    input  adrs_clm, busy, done, score
  );

  modport slave (
    input  start, w_in, act_in,
    output adrs_clm, busy, done, score
  );
endinterface

// File: rtl/neuron_mac_c9.sv
// rtl/neuron_mac_c9.sv - column-9 output-neuron MAC: sequences ROM addresses, accumulates w*act, rescales and saturates
`timescale 1ns/1ps
module neuron_mac_c9 #(
  parameter int N_IN  = 300,
  parameter int ADR_W = 9,
  parameter int W_W   = 21,
  parameter int ACT_W = 16,
  parameter int ACC_W = 46,
  parameter int SHIFT = 8,
  parameter int OUT_W = 16
) (
  input logic            clk,
  input logic            rst,
  neuron_mac_c9_if.slave bus
);

  localparam int P_W = W_W + ACT_W;
  localparam logic [ADR_W-1:0] LAST_ADR = ADR_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FLUSH,
    OUT,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [ADR_W-1:0]        adrs;
  logic signed [P_W-1:0]   prod;
  logic                    pv;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic [OUT_W-1:0]        score_q;
  logic [OUT_W-1:0]        score_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        bus.busy = 1'b1;
        if (adrs == LAST_ADR) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        bus.busy  = 1'b1;
        state_nxt = OUT;
      end
      OUT: begin
        bus.busy  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Rescale is an arithmetic shift, so negative sums floor toward minus infinity.
  assign shifted = acc >>> SHIFT;

  always_comb begin
    score_sat = shifted[OUT_W-1:0];
    if (shifted > SAT_HI) begin
      score_sat = SAT_HI[OUT_W-1:0];
    end else if (shifted < SAT_LO) begin
      score_sat = SAT_LO[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adrs    <= '0;
      prod    <= '0;
      pv      <= 1'b0;
      acc     <= '0;
      score_q <= '0;
    end else begin
      // The product pipeline stage drains one edge behind the address counter.
      if (pv) begin
        acc <= acc + {{(ACC_W - P_W){prod[P_W-1]}}, prod};
      end
      case (state)
        IDLE: begin
          if (bus.start) begin
            adrs <= '0;
            acc  <= '0;
            pv   <= 1'b0;
          end
        end
        RUN: begin
          prod <= P_W'($signed(bus.w_in)) * P_W'($signed(bus.act_in));
          pv   <= 1'b1;
          if (adrs < LAST_ADR) begin
            adrs <= adrs + 1'b1;
          end
        end
        FLUSH: begin
          pv <= 1'b0;
        end
        OUT: begin
          score_q <= score_sat;
        end
        DONE: begin
          adrs <= '0;
        end
        default: begin
          pv <= 1'b0;
        end
      endcase
    end
  end

  assign bus.adrs_clm = adrs;
  assign bus.score    = score_q;

endmodule

// File: tb/tb_neuron_mac_c9.sv
// tb/tb_neuron_mac_c9.sv - randomized and directed checks of neuron_mac_c9 against a dot-product model
`timescale 1ns/1ps
module tb_neuron_mac_c9;
  localparam int N_IN = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  neuron_mac_c9_if bus ();
  neuron_mac_c9_if bus0 ();

  logic signed [20:0] w_mem [0:511];
  logic signed [15:0] a_mem [0:511];

  assign bus.w_in    = w_mem[bus.adrs_clm];
  assign bus.act_in  = a_mem[bus.adrs_clm];
  assign bus0.w_in   = w_mem[bus0.adrs_clm];
  assign bus0.act_in = a_mem[bus0.adrs_clm];

  neuron_mac_c9 #(.SHIFT(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  neuron_mac_c9 #(.SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int max_adrs = 0;

  always @(negedge clk) begin
    if (!rst && bus.done) done_cnt++;
    if (int'(bus.adrs_clm) > max_adrs) max_adrs = int'(bus.adrs_clm);
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(input int shift);
    longint s = 0;
    for (int i = 0; i < N_IN; i++) s += longint'(w_mem[i]) * longint'(a_mem[i]);
    s = s >>> shift;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic set_start(input logic v);
    bus.start  = v;
    bus0.start = v;
  endtask

  task automatic fill(input int mode, input longint wv, input longint av);
    for (int i = 0; i < 512; i++) begin
      w_mem[i] = '0;
      a_mem[i] = '0;
      if (i < N_IN) begin
        if (mode == 1) begin
          w_mem[i] = 21'($urandom);
          a_mem[i] = 16'($urandom);
        end else if (mode == 2) begin
          w_mem[i] = 21'(wv);
          a_mem[i] = 16'(av);
        end
      end
    end
  endtask

  // One start pulse, then watch the run cycle by cycle; c counts cycles after the start edge.
  task automatic run_one(input string tag, input int pulse_at);
    int got_cyc = -1;
    int busy_n = 0;
    int adr_err = 0;
    int d0;
    longint e8 = model(8);
    longint e0 = model(0);
    d0 = done_cnt;
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    for (int c = 1; c <= 400 && got_cyc < 0; c++) begin
      @(negedge clk);
      set_start(c == pulse_at);
      if (bus.busy) busy_n++;
      if (c <= 303 && int'(bus.adrs_clm) != ((c - 1 < N_IN - 1) ? c - 1 : N_IN - 1)) adr_err++;
      if (bus.done) got_cyc = c;
    end
    set_start(1'b0);
    check({tag, "_done_lat"}, got_cyc, 303);
    check({tag, "_busy_cycles"}, busy_n, 302);
    check({tag, "_adrs_seq_err"}, adr_err, 0);
    check({tag, "_score_s8"}, longint'($signed(bus.score)), e8);
    check({tag, "_score_s0"}, longint'($signed(bus0.score)), e0);
    repeat (5) @(posedge clk);
    #1;
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_score_held"}, longint'($signed(bus.score)), e8);
  endtask

  initial begin
    int d0;
    int seen;
    int incs;
    int prev;
    int dc [2];
    longint e8;
    set_start(1'b0);
    fill(0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_adrs", bus.adrs_clm, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_score", bus.score, 0);
    @(negedge clk);
    rst = 1'b0;

    fill(0, 0, 0);
    w_mem[0] = 21'sd352;
    a_mem[0] = 16'sd256;
    run_one("single_a0", 0);
    check("single_a0_value", longint'($signed(bus.score)), 352);

    fill(0, 0, 0);
    w_mem[1] = 21'sd625;
    a_mem[1] = 16'sd256;
    run_one("single_a1", 0);
    check("single_a1_value", longint'($signed(bus.score)), 625);

    fill(1, 0, 0);
    for (int i = 0; i < N_IN; i++) a_mem[i] = '0;
    run_one("zero_act_restart", 50);
    check("zero_act_value", longint'($signed(bus.score)), 0);

    fill(2, 1048575, 32767);
    run_one("sat_pos", 0);
    check("sat_pos_value", longint'($signed(bus.score)), 32767);
    fill(2, -1048576, 32767);
    run_one("sat_neg", 0);
    check("sat_neg_value", longint'($signed(bus.score)), -32768);

    fill(2, -1, 1);
    run_one("minus_one", 0);
    check("minus_one_s8", longint'($signed(bus.score)), -2);
    check("minus_one_s0", longint'($signed(bus0.score)), -300);

    for (int r = 0; r < 4; r++) begin
      fill(1, 0, 0);
      run_one($sformatf("rand%0d", r), 0);
    end

    // Reset in the middle of a run: partial sum dropped, no done.
    fill(1, 0, 0);
    @(negedge clk);
    set_start(1'b1);
    @(posedge clk);
    #1;
    set_start(1'b0);
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (int'(bus.adrs_clm) == 100) seen = 1;
    end
    check("rst_mid_reach100", seen, 1);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_adrs", bus.adrs_clm, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_score", bus.score, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (320) @(posedge clk);
    #1;
    check("rst_mid_no_done", done_cnt - d0, 0);
    run_one("after_rst", 0);

    // Start held high: back-to-back runs.
    fill(1, 0, 0);
    e8 = model(8);
    seen = 0;
    incs = 0;
    @(negedge clk);
    prev = int'(bus.adrs_clm);
    set_start(1'b1);
    for (int c = 0; c < 800 && seen < 2; c++) begin
      @(negedge clk);
      if (bus.busy && int'(bus.adrs_clm) != prev) incs++;
      prev = int'(bus.adrs_clm);
      if (bus.done) begin
        dc[seen] = c;
        seen++;
      end
    end
    set_start(1'b0);
    check("hold_done_count", seen, 2);
    if (seen == 2) check("hold_done_spacing", dc[1] - dc[0], N_IN + 4);
    check("hold_adrs_increments", incs, 2 * (N_IN - 1));
    check("hold_score", longint'($signed(bus.score)), e8);
    repeat (4) @(posedge clk);
    #1;
    check("hold_idle_after", bus.busy, 0);
    check("max_adrs", max_adrs, N_IN - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
